// File: rtl/shift_count_register.sv
// rtl/shift_count_register.sv - parametrised load/clear/count/shift datapath register
module shift_count_register #(
    parameter int                 WIDTH     = 16,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] in,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_CLEAR = 3'b010,
        MODE_INC   = 3'b011,
        MODE_DEC   = 3'b100,
        MODE_SHL   = 3'b101,
        MODE_SHR   = 3'b110,
        MODE_ASR   = 3'b111
    } mode_e;

    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic [WIDTH:0]   inc_sum;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);
    assign inc_sum  = {1'b0, out_q} + (WIDTH+1)'(1);

    always_comb begin
        out_d   = out_q;
        carry_d = carry_q;
        if (en) begin
            case (mode_sel)
                MODE_HOLD: ;
                MODE_LOAD: begin
                    out_d   = in;
                    carry_d = 1'b0;
                end
                MODE_CLEAR: begin
                    out_d   = '0;
                    carry_d = 1'b0;
                end
                MODE_INC: begin
                    out_d   = inc_sum[WIDTH-1:0];
                    carry_d = inc_sum[WIDTH];
                end
                // borrow only when counting down through zero
                MODE_DEC: begin
                    out_d   = out_q - WIDTH'(1);
                    carry_d = (out_q == '0);
                end
                MODE_SHL: begin
                    out_d   = {out_q[WIDTH-2:0], serial_in};
                    carry_d = out_q[WIDTH-1];
                end
                MODE_SHR: begin
                    out_d   = {serial_in, out_q[WIDTH-1:1]};
                    carry_d = out_q[0];
                end
                MODE_ASR: begin
                    out_d   = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
                    carry_d = out_q[0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= RESET_VAL;
            carry_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign out   = out_q;
    assign carry = carry_q;
    assign zero  = (out_q == '0);

endmodule

// File: tb/tb_shift_count_register.sv
// tb/tb_shift_count_register.sv - randomized model-based bench for shift_count_register
module tb_shift_count_register;

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, CLEAR = 3'd2, INC = 3'd3,
                           DEC = 3'd4, SHL = 3'd5, SHR = 3'd6, ASR = 3'd7;

    logic        clk = 1'b0;
    logic        reset16, en16, si16, carry16, zero16;
    logic [2:0]  mode16;
    logic [15:0] in16, out16;
    logic        reset8, en8, si8, carry8, zero8;
    logic [2:0]  mode8;
    logic [7:0]  in8, out8;

    int checks = 0;
    int errors = 0;

    longint m16, m8;
    bit     c16, c8;

    always #5 clk = ~clk;

    shift_count_register dut16 (
        .clk(clk), .reset(reset16), .en(en16), .mode(mode16), .in(in16),
        .serial_in(si16), .out(out16), .carry(carry16), .zero(zero16)
    );

    shift_count_register #(.WIDTH(8), .RESET_VAL(8'h5A)) dut8 (
        .clk(clk), .reset(reset8), .en(en8), .mode(mode8), .in(in8),
        .serial_in(si8), .out(out8), .carry(carry8), .zero(zero8)
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: register treated as an unsigned integer in [0, 2^w)
    task automatic model_op(input int w, input logic [2:0] md, input bit e, input longint vin,
                            input bit si, inout longint v, inout bit c);
        longint full, half;
        full = longint'(1) << w;
        half = full / 2;
        if (!e) return;
        case (md)
            LOAD:  begin v = vin % full; c = 0; end
            CLEAR: begin v = 0; c = 0; end
            INC:   begin c = (v == full - 1); v = (v + 1) % full; end
            DEC:   begin c = (v == 0); v = (v + full - 1) % full; end
            SHL:   begin c = (v >= half); v = (v * 2 + longint'(si)) % full; end
            SHR:   begin c = (v % 2 == 1); v = v / 2 + longint'(si) * half; end
            ASR:   begin c = (v % 2 == 1); v = v / 2 + ((v >= half) ? half : 0); end
            default: ;
        endcase
    endtask

    task automatic step16(input bit e, input logic [2:0] md, input logic [15:0] d, input bit si);
        en16 = e; mode16 = md; in16 = d; si16 = si;
        @(posedge clk); #1;
        model_op(16, md, e, longint'(d), si, m16, c16);
        check_eq("out16", longint'(out16), m16);
        check_eq("carry16", longint'(carry16), longint'(c16));
        check_eq("zero16", longint'(zero16), longint'(m16 == 0));
    endtask

    task automatic step8(input bit e, input logic [2:0] md, input logic [7:0] d, input bit si);
        en8 = e; mode8 = md; in8 = d; si8 = si;
        @(posedge clk); #1;
        if (reset8) begin
            m8 = 'h5A; c8 = 0;
        end else begin
            model_op(8, md, e, longint'(d), si, m8, c8);
        end
        check_eq("out8", longint'(out8), m8);
        check_eq("carry8", longint'(carry8), longint'(c8));
        check_eq("zero8", longint'(zero8), longint'(m8 == 0));
    endtask

    initial begin
        reset16 = 1; en16 = 0; mode16 = HOLD; in16 = '0; si16 = 0;
        reset8  = 1; en8  = 0; mode8  = HOLD; in8  = '0; si8  = 0;
        m16 = 0; c16 = 0; m8 = 'h5A; c8 = 0;

        #2;
        check_eq("rst_out16", longint'(out16), 0);
        check_eq("rst_carry16", longint'(carry16), 0);
        check_eq("rst_zero16", longint'(zero16), 1);
        check_eq("rst_out8", longint'(out8), 'h5A);
        check_eq("rst_zero8", longint'(zero8), 0);
        @(posedge clk); #1;
        reset16 = 0; reset8 = 0;

        step16(1, LOAD, 16'hA5A5, 0);
        check_eq("load_a5a5", longint'(out16), 'hA5A5);
        step16(1, LOAD, 16'hFFFE, 0);
        step16(1, INC, 16'h0, 0);
        check_eq("inc_ffff", longint'(out16), 'hFFFF);
        step16(1, INC, 16'h0, 0);
        check_eq("inc_wrap_carry", longint'(carry16), 1);
        check_eq("inc_wrap_zero", longint'(zero16), 1);
        step16(1, CLEAR, 16'h0, 0);
        step16(1, DEC, 16'h0, 0);
        check_eq("dec_wrap", longint'({carry16, out16}), 'h1FFFF);
        step16(1, DEC, 16'h0, 0);
        check_eq("dec_fffe", longint'({carry16, out16}), 'h0FFFE);
        step16(1, LOAD, 16'h8001, 0);
        step16(1, SHL, 16'h0, 0);
        check_eq("shl", longint'({carry16, out16}), 'h10002);
        step16(1, LOAD, 16'h8001, 0);
        step16(1, SHR, 16'h0, 1);
        check_eq("shr", longint'({carry16, out16}), 'h1C000);
        step16(1, LOAD, 16'h8002, 0);
        step16(1, ASR, 16'h0, 1);
        check_eq("asr", longint'({carry16, out16}), 'h0C001);
        step16(1, LOAD, 16'h1234, 0);
        step16(0, INC, 16'h0, 0);
        step16(0, CLEAR, 16'h0, 0);
        step16(0, SHL, 16'h0, 1);
        check_eq("en_gate", longint'({carry16, out16}), 'h01234);

        for (int i = 0; i < 400; i++)
            step16($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                   16'($urandom), 1'($urandom_range(0, 1)));

        step8(1, LOAD, 8'h10, 0);
        for (int i = 0; i < 3; i++) step8(1, INC, 8'h0, 0);
        check_eq("inc8_13", longint'(out8), 'h13);
        #3 reset8 = 1;
        #1;
        check_eq("mid_rst_out8", longint'(out8), 'h5A);
        check_eq("mid_rst_carry8", longint'(carry8), 0);
        m8 = 'h5A; c8 = 0;
        step8(1, INC, 8'h0, 0);
        step8(1, LOAD, 8'hFF, 0);
        check_eq("rst_hold8", longint'(out8), 'h5A);
        reset8 = 0;
        for (int i = 0; i < 400; i++)
            step8($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  8'($urandom), 1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
